// File: rtl/csr_row_streamer.sv
// Captures one CSR frame (packed nonzeros plus per-row lengths) and streams it
// out as dense rows, one row per handshake, each lane taken from the running nonzero pointer.
module csr_row_streamer #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_OF_COLS = 5,
    parameter int NUM_OF_ROWS = 5,
    parameter int NNZ_SIZE    = 8,
    localparam int CW = $clog2(NUM_OF_COLS),
    localparam int LW = $clog2(NUM_OF_COLS + 1),
    localparam int RW = $clog2(NUM_OF_ROWS + 1),
    localparam int PW = $clog2(NNZ_SIZE + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [CW*NNZ_SIZE-1:0]            col_idx_i,
    input  logic [DATA_WIDTH*NNZ_SIZE-1:0]    value_i,
    input  logic [LW*NUM_OF_ROWS-1:0]         row_len_i,
    input  logic [NUM_OF_ROWS-1:0]            row_flag_i,
    input  logic [RW-1:0]                     num_rows_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [RW-1:0]                     out_row_o,
    output logic [LW-1:0]                     out_len_o,
    output logic                              out_flag_o,
    output logic [CW*NUM_OF_COLS-1:0]         out_col_idx_o,
    output logic [DATA_WIDTH*NUM_OF_COLS-1:0] out_value_o,
    output logic                              out_last_o,
    output logic                              done_o,
    output logic                              err_o
);

    localparam int IW  = (NNZ_SIZE > 1) ? $clog2(NNZ_SIZE) : 1;
    localparam int RIW = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1;
    localparam int SW  = ((PW > LW) ? PW : LW) + 1;

    typedef enum logic {IDLE, STREAM} state_t;
    state_t state_q, state_d;

    // Unpacked views: index k holds entry/row k (entry 0 arrives in the MS slice).
    logic [NNZ_SIZE-1:0][CW-1:0]         in_col, cap_col_q, src_col;
    logic [NNZ_SIZE-1:0][DATA_WIDTH-1:0] in_val, cap_val_q, src_val;
    logic [NUM_OF_ROWS-1:0][LW-1:0]      in_len, cap_len_q, src_len;
    logic [NUM_OF_ROWS-1:0]              in_flag, cap_flag_q, src_flag;

    for (genvar k = 0; k < NNZ_SIZE; k++) begin : g_nnz
        assign in_col[k] = col_idx_i[(NNZ_SIZE-1-k)*CW +: CW];
        assign in_val[k] = value_i[(NNZ_SIZE-1-k)*DATA_WIDTH +: DATA_WIDTH];
    end
    for (genvar r = 0; r < NUM_OF_ROWS; r++) begin : g_row
        assign in_len[r]  = row_len_i[(NUM_OF_ROWS-1-r)*LW +: LW];
        assign in_flag[r] = row_flag_i[NUM_OF_ROWS-1-r];
    end

    logic [PW-1:0] ptr_q, ptr_d, ptr_src, ptr_adv;
    logic [RW-1:0] row_q, row_d, row_src, row_nxt;
    logic [RW-1:0] nrows_q, nrows_d, nrows_src, nrows_in;
    logic          err_q, err_d, done_q, done_d;
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d, out_flag_q, out_flag_d;
    logic [RW-1:0] out_row_q, out_row_d;
    logic [LW-1:0] out_len_q, out_len_d;
    logic [NUM_OF_COLS-1:0][CW-1:0]         out_col_q, out_col_d, lane_col;
    logic [NUM_OF_COLS-1:0][DATA_WIDTH-1:0] out_val_q, out_val_d, lane_val;
    logic          idle, cap_en, load, row_err, cur_flag, cur_last;
    logic [LW-1:0] cur_len;
    logic [SW-1:0] ptr_sum;

    // Row 0 is built straight from the inputs during the accept cycle, which gives latency 1.
    assign idle      = (state_q == IDLE);
    assign src_col   = idle ? in_col  : cap_col_q;
    assign src_val   = idle ? in_val  : cap_val_q;
    assign src_len   = idle ? in_len  : cap_len_q;
    assign src_flag  = idle ? in_flag : cap_flag_q;
    assign ptr_src   = idle ? '0 : ptr_q;
    assign row_src   = idle ? '0 : row_q;
    assign nrows_in  = (num_rows_i > RW'(NUM_OF_ROWS)) ? RW'(NUM_OF_ROWS) : num_rows_i;
    assign nrows_src = idle ? nrows_in : nrows_q;

    assign cur_len  = src_len[row_src[RIW-1:0]];
    assign cur_flag = src_flag[row_src[RIW-1:0]];
    assign row_nxt  = row_src + RW'(1);
    assign cur_last = (row_nxt == nrows_src);
    assign ptr_sum  = SW'(ptr_src) + SW'(cur_len);
    assign row_err  = (ptr_sum > SW'(NNZ_SIZE)) || (cur_len > LW'(NUM_OF_COLS));
    // Saturate so an overrun cannot wrap the pointer back into valid entries.
    assign ptr_adv  = (ptr_sum > SW'(NNZ_SIZE)) ? PW'(NNZ_SIZE) : PW'(ptr_sum);

    for (genvar c = 0; c < NUM_OF_COLS; c++) begin : g_lane
        logic [SW-1:0] idx;
        logic          sel;
        assign idx = SW'(ptr_src) + SW'(c);
        assign sel = (LW'(c) < cur_len) && (idx < SW'(NNZ_SIZE));
        assign lane_col[NUM_OF_COLS-1-c] = sel ? src_col[idx[IW-1:0]] : '0;
        assign lane_val[NUM_OF_COLS-1-c] = sel ? src_val[idx[IW-1:0]] : '0;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        row_d       = row_q;
        nrows_d     = nrows_q;
        err_d       = err_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        out_len_d   = out_len_q;
        out_flag_d  = out_flag_q;
        out_col_d   = out_col_q;
        out_val_d   = out_val_q;
        out_last_d  = out_last_q;
        cap_en      = 1'b0;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    cap_en  = 1'b1;
                    nrows_d = nrows_in;
                    err_d   = (num_rows_i > RW'(NUM_OF_ROWS));
                    ptr_d   = '0;
                    row_d   = '0;
                    if (nrows_in == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = STREAM;
                        load    = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (out_valid_q && out_ready_i && out_last_q) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                end else if ((!out_valid_q || out_ready_i) && (row_q < nrows_q)) begin
                    load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            out_valid_d = 1'b1;
            out_row_d   = row_src;
            out_len_d   = cur_len;
            out_flag_d  = cur_flag;
            out_col_d   = lane_col;
            out_val_d   = lane_val;
            out_last_d  = cur_last;
            ptr_d       = ptr_adv;
            row_d       = row_nxt;
            err_d       = err_d | row_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            row_q       <= '0;
            nrows_q     <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_len_q   <= '0;
            out_flag_q  <= 1'b0;
            out_col_q   <= '0;
            out_val_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            row_q       <= row_d;
            nrows_q     <= nrows_d;
            err_q       <= err_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_len_q   <= out_len_d;
            out_flag_q  <= out_flag_d;
            out_col_q   <= out_col_d;
            out_val_q   <= out_val_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            cap_col_q  <= in_col;
            cap_val_q  <= in_val;
            cap_len_q  <= in_len;
            cap_flag_q <= in_flag;
        end
    end

    assign in_ready_o    = idle;
    assign out_valid_o   = out_valid_q;
    assign out_row_o     = out_row_q;
    assign out_len_o     = out_len_q;
    assign out_flag_o    = out_flag_q;
    assign out_col_idx_o = out_col_q;
    assign out_value_o   = out_val_q;
    assign out_last_o    = out_last_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_csr_row_streamer.sv
// Scoreboard bench for csr_row_streamer: directed frames push hand-computed rows,
// a negedge monitor pops and compares on every output handshake.
module tb_csr_row_streamer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [23:0] col_idx_i = '0;
    logic [63:0] value_i = '0;
    logic [14:0] row_len_i = '0;
    logic [4:0]  row_flag_i = '0;
    logic [2:0]  num_rows_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [2:0]  out_row_o;
    logic [2:0]  out_len_o;
    logic        out_flag_o;
    logic [14:0] out_col_idx_o;
    logic [39:0] out_value_o;
    logic        out_last_o;
    logic        done_o;
    logic        err_o;

    csr_row_streamer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .col_idx_i(col_idx_i), .value_i(value_i), .row_len_i(row_len_i),
        .row_flag_i(row_flag_i), .num_rows_i(num_rows_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_row_o(out_row_o), .out_len_o(out_len_o), .out_flag_o(out_flag_o),
        .out_col_idx_o(out_col_idx_o), .out_value_o(out_value_o),
        .out_last_o(out_last_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, done_cnt = 0, hold_cnt = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Row record: {row, len, flag, cols, vals, last, err} = 64 bits.
    task automatic push(input logic [2:0] r, input logic [2:0] l, input logic f,
                        input logic [14:0] c, input logic [39:0] v, input logic last, input logic e);
        exp_q.push_back({r, l, f, c, v, last, e});
    endtask

    task automatic set_frame(input logic [23:0] c, input logic [63:0] v, input logic [14:0] l,
                             input logic [4:0] f, input logic [2:0] n);
        col_idx_i = c; value_i = v; row_len_i = l; row_flag_i = f; num_rows_i = n;
    endtask

    task automatic basic_frame(input logic [2:0] n);
        set_frame({3'd0,3'd3,3'd1,3'd2,3'd4,3'd0,3'd1,3'd3},
                  {8'd1,8'd2,8'd3,8'd4,8'd5,8'd6,8'd7,8'd8},
                  {3'd2,3'd0,3'd3,3'd1,3'd2}, 5'b10101, n);
    endtask

    task automatic push_basic(input logic e, input int upto);
        if (upto > 0) push(3'd0, 3'd2, 1'b1, {3'd0,3'd3,9'd0}, {8'd1,8'd2,24'd0}, 1'b0, e);
        if (upto > 1) push(3'd1, 3'd0, 1'b0, 15'd0, 40'd0, 1'b0, e);
        if (upto > 2) push(3'd2, 3'd3, 1'b1, {3'd1,3'd2,3'd4,6'd0}, {8'd3,8'd4,8'd5,16'd0}, 1'b0, e);
        if (upto > 3) push(3'd3, 3'd1, 1'b0, {3'd0,12'd0}, {8'd6,32'd0}, 1'b0, e);
        if (upto > 4) push(3'd4, 3'd2, 1'b1, {3'd1,3'd3,9'd0}, {8'd7,8'd8,24'd0}, 1'b1, e);
    endtask

    // Returns at accept edge + 1.
    task automatic accept();
        int n = 0;
        while (!in_ready_o && n < 100) begin @(posedge clk); #1; n++; end
        chk("accept_ready", 64'(in_ready_o), 64'd1);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (!done_o && n < 60) begin @(negedge clk); n++; end
        chk({name, "_done"}, 64'(done_o), 64'd1);
        chk({name, "_ready_at_done"}, 64'(in_ready_o), 64'd1);
        @(negedge clk);
        chk({name, "_done_pulse"}, 64'(done_o), 64'd0);
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done_o) done_cnt++;
            if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_row got_row=%0d exp=none", out_row_o);
                end else begin
                    chk(out_ready_i ? "row" : "hold",
                        {out_row_o, out_len_o, out_flag_o, out_col_idx_o, out_value_o, out_last_o, err_o},
                        exp_q[0]);
                    if (out_ready_i) void'(exp_q.pop_front());
                    else hold_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, h0;
        #12;
        chk("reset_outputs", {out_valid_o, done_o, err_o, out_last_o, out_row_o, out_len_o,
                              out_flag_o, out_col_idx_o, out_value_o}, 64'd0);
        chk("reset_ready", 64'(in_ready_o), 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame at full rate
        d0 = done_cnt;
        basic_frame(3'd5); push_basic(1'b0, 5);
        accept();
        chk("latency1", {out_valid_o, out_row_o}, {1'b1, 3'd0});
        wait_done("basic");
        chk("basic_done_cnt", 64'(done_cnt), 64'(d0 + 1));

        // Backpressure on row 2
        h0 = hold_cnt;
        basic_frame(3'd5); push_basic(1'b0, 5);
        accept();
        repeat (2) @(posedge clk); #1 out_ready_i = 1'b0;
        repeat (3) @(posedge clk); #1 out_ready_i = 1'b1;
        wait_done("bp");
        chk("bp_holds", 64'(hold_cnt), 64'(h0 + 3));

        // Overrun: second row runs past NNZ_SIZE
        set_frame({3'd0,3'd1,3'd2,3'd3,3'd4,3'd0,3'd1,3'd2},
                  {8'd10,8'd11,8'd12,8'd13,8'd14,8'd15,8'd16,8'd17},
                  {3'd5,3'd5,9'd0}, 5'b00000, 3'd2);
        push(3'd0, 3'd5, 1'b0, {3'd0,3'd1,3'd2,3'd3,3'd4}, {8'd10,8'd11,8'd12,8'd13,8'd14}, 1'b0, 1'b0);
        push(3'd1, 3'd5, 1'b0, {3'd0,3'd1,3'd2,6'd0}, {8'd15,8'd16,8'd17,16'd0}, 1'b1, 1'b1);
        accept();
        wait_done("ovr");
        chk("ovr_err_sticky", 64'(err_o), 64'd1);

        // Empty frame
        d0 = done_cnt;
        set_frame('0, '0, '0, '0, 3'd0);
        accept();
        chk("empty_done", {done_o, in_ready_o, out_valid_o, err_o}, {1'b1, 1'b1, 1'b0, 1'b0});
        @(posedge clk); #1;
        chk("empty_after", {done_o, in_ready_o, out_valid_o}, {1'b0, 1'b1, 1'b0});
        repeat (3) @(posedge clk); #1;
        chk("empty_done_cnt", 64'(done_cnt), 64'(d0 + 1));

        // Reset during row 2
        d0 = done_cnt;
        basic_frame(3'd5); push_basic(1'b0, 2);
        accept();
        repeat (2) @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("rst_outputs", {out_valid_o, done_o, err_o, out_last_o, out_row_o, out_len_o,
                            out_flag_o, out_col_idx_o, out_value_o}, 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd1);
        repeat (2) @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release", {in_ready_o, out_valid_o}, {1'b1, 1'b0});
        repeat (4) @(posedge clk); #1;
        chk("rst_no_done", 64'(done_cnt), 64'(d0));
        chk("rst_drained", 64'(exp_q.size()), 64'd0);

        // Second frame held on in_valid while the first streams
        basic_frame(3'd5); push_basic(1'b0, 5);
        push(3'd0, 3'd1, 1'b0, {3'd4,12'd0}, {8'h21,32'd0}, 1'b0, 1'b0);
        push(3'd1, 3'd2, 1'b1, {3'd2,3'd1,9'd0}, {8'h22,8'h23,24'd0}, 1'b1, 1'b0);
        accept();
        set_frame({3'd4,3'd2,3'd1,15'd0}, {8'h21,8'h22,8'h23,40'd0}, {3'd1,3'd2,9'd0}, 5'b01000, 3'd2);
        in_valid_i = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("b2b_done", {done_o, in_ready_o, out_valid_o}, {1'b1, 1'b1, 1'b0});
        @(posedge clk); #1;
        chk("b2b_row0", {out_valid_o, out_row_o, out_len_o, in_ready_o}, {1'b1, 3'd0, 3'd1, 1'b0});
        in_valid_i = 1'b0;
        wait_done("b2b");

        // num_rows above NUM_OF_ROWS clamps and flags
        basic_frame(3'd7); push_basic(1'b1, 5);
        accept();
        wait_done("clamp");

        // Row longer than NUM_OF_COLS, next row ends exactly at NNZ_SIZE
        set_frame({3'd0,3'd1,3'd2,3'd3,3'd4,3'd0,3'd1,3'd2},
                  {8'd1,8'd2,8'd3,8'd4,8'd5,8'd6,8'd7,8'd8},
                  {3'd7,3'd1,9'd0}, 5'b11000, 3'd2);
        push(3'd0, 3'd7, 1'b1, {3'd0,3'd1,3'd2,3'd3,3'd4}, {8'd1,8'd2,8'd3,8'd4,8'd5}, 1'b0, 1'b1);
        push(3'd1, 3'd1, 1'b1, {3'd2,12'd0}, {8'd8,32'd0}, 1'b1, 1'b1);
        accept();
        wait_done("wide");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/csr_row_streamer.md
CSR_ROW_STREAMER -- requirements
Module: csr_row_streamer

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of one value entry.
- REQ-002 SHALL have parameter NUM_OF_COLS, default 5: max row length and output lanes per row.
- REQ-003 SHALL have parameter NUM_OF_ROWS, default 5: max rows per frame.
- REQ-004 SHALL have parameter NNZ_SIZE, default 8: max nonzeros per frame.
- REQ-005 SHALL use derived widths:
  - CW = $clog2(NUM_OF_COLS)
  - LW = $clog2(NUM_OF_COLS+1)
  - RW = $clog2(NUM_OF_ROWS+1)
  - PW = $clog2(NNZ_SIZE+1)
- REQ-006 SHALL have port `clk`, input, 1 bit: single clock, rising edge.
- REQ-007 SHALL have port `rst_n`, input, 1 bit: asynchronous, active-low reset.
- REQ-008 SHALL have port `in_valid_i`, input, 1 bit: frame present.
- REQ-009 SHALL have port `in_ready_o`, output, 1 bit: frame accepted when high with `in_valid_i`.
- REQ-010 SHALL have port `col_idx_i`, input, CW*NNZ_SIZE: column indices, entry 0 in the MS slice.
- REQ-011 SHALL have port `value_i`, input, DATA_WIDTH*NNZ_SIZE: values, entry 0 in the MS slice.
- REQ-012 SHALL have port `row_len_i`, input, LW*NUM_OF_ROWS: per-row nonzero count, row 0 in the MS slice.
- REQ-013 SHALL have port `row_flag_i`, input, NUM_OF_ROWS: per-row flag, row 0 at the MSB.
- REQ-014 SHALL have port `num_rows_i`, input, RW: rows in this frame (0..NUM_OF_ROWS).
- REQ-015 SHALL have port `out_valid_o`, output, 1 bit: row present.
- REQ-016 SHALL have port `out_ready_i`, input, 1 bit: downstream accepts row.
- REQ-017 SHALL have port `out_row_o`, output, RW: index of the emitted row.
- REQ-018 SHALL have port `out_len_o`, output, LW: row length.
- REQ-019 SHALL have port `out_flag_o`, output, 1 bit: row flag.
- REQ-020 SHALL have port `out_col_idx_o`, output, CW*NUM_OF_COLS: lane 0 in the MS slice.
- REQ-021 SHALL have port `out_value_o`, output, DATA_WIDTH*NUM_OF_COLS: lane 0 in the MS slice.
- REQ-022 SHALL have port `out_last_o`, output, 1 bit: emitted row is the final row of the frame.
- REQ-023 SHALL have port `done_o`, output, 1 bit: one-cycle pulse at frame completion.
- REQ-024 SHALL have port `err_o`, output, 1 bit: sticky overrun flag, cleared at the next frame accept.

Function
- REQ-025 SHALL implement an FSM with states IDLE and STREAM; `in_ready_o` = 1 only in IDLE.
- REQ-026 SHALL, on accept in IDLE, register all frame inputs, clear the read pointer `ptr` (PW) and row counter, and clear `err_o`:
  - num_rows_i > 0: go to STREAM.
  - num_rows_i = 0: stay in IDLE and pulse `done_o` next cycle.
- REQ-027 SHALL ignore `in_valid_i` while in STREAM; the captured frame is not disturbed.
- REQ-028 SHALL register all outputs. The output register loads the next row when in STREAM and (!out_valid_o || out_ready_i).
- REQ-029 SHALL raise `out_valid_o` with row 0 in the cycle after frame accept (latency 1).
- REQ-030 SHALL fill lane c of row r as follows:
  - c < len(r) and ptr+c < NNZ_SIZE: col_idx[ptr+c] and value[ptr+c].
  - Otherwise: zero.
- REQ-031 SHALL advance `ptr` by len(r) after each row load. Row start positions are the prefix sum of row lengths; no start index is supplied.
- REQ-032 SHALL set `err_o` if ptr+len(r) > NNZ_SIZE or len(r) > NUM_OF_COLS; out-of-range lanes are zero and `out_len_o` is still the raw len(r).
- REQ-033 SHALL emit a zero-length row with out_len_o = 0 and all lanes zero.
- REQ-034 SHALL keep every output stable while out_valid_o && !out_ready_i.
- REQ-035 SHALL set out_last_o = 1 when out_row_o = num_rows-1.
- REQ-036 SHALL, on the handshake of the last row:
  - drop out_valid_o next cycle unless a new row loads;
  - return to IDLE;
  - pulse done_o for one cycle;
  - raise in_ready_o in the same cycle as done_o.
- REQ-037 SHALL support back-to-back rows at one row per cycle while out_ready_i stays high.
- REQ-038 SHALL clamp num_rows_i > NUM_OF_ROWS to NUM_OF_ROWS and set err_o.

Reset
- REQ-039 SHALL, while rst_n = 0, asynchronously force the following; the captured frame contents need not be reset:
  - FSM = IDLE; ptr = 0; row counter = 0.
  - out_valid_o = 0; done_o = 0; err_o = 0; out_last_o = 0.
  - out_row_o, out_len_o, out_flag_o, out_col_idx_o, out_value_o all 0.
- REQ-040 SHALL, when reset is asserted mid-STREAM, abandon the frame with no done_o; in_ready_o = 1 in the first cycle after release.

Verification
- REQ-041 SHALL cover the basic frame. Stimulus: lengths {2,0,3,1,2}, col_idx {0,3,1,2,4,0,1,3}, values 1..8, ready held 1. Response, one row per cycle:
  - row0 cols {0,3} vals {1,2};
  - row1 all zero;
  - row2 vals {3,4,5};
  - row3 val {6};
  - row4 vals {7,8}, out_last_o = 1;
  - then done_o.
- REQ-042 SHALL cover backpressure: same frame, out_ready_i low 3 cycles at row 2 -> row 2 outputs unchanged for 3 cycles, no row skipped or duplicated.
- REQ-043 SHALL cover the overrun case: lengths {5,5}, NNZ 8 -> err_o = 1, and row1 lanes 3..4 are zero.
- REQ-044 SHALL cover the empty frame: num_rows_i = 0 -> out_valid_o never rises, done_o pulses once, in_ready_o stays 1.
- REQ-045 SHALL cover reset mid-stream: rst_n low during row 2 -> all outputs 0 immediately, in_ready_o = 1 after release, no done_o.
- REQ-046 SHALL cover a second frame: in_valid_i asserted during STREAM, then a new frame offered the cycle done_o pulses -> the second frame is accepted only in IDLE, and its row 0 appears one cycle later.
